// File: rtl/video_stream_gen.sv
// Raster test-pattern generator: emits lines/frames of (x + y) pixels separated by H/V blanking.
// Define VIDEO_STREAM_GEN_FRAME_SHIFT_EN to add a per-frame counter so the pattern moves each frame.
module video_stream_gen #(
  parameter int PIXEL_WIDTH   = 12,
  parameter int SPARSE_OUTPUT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [15:0]            line_size,
  input  logic [15:0]            line_count,
  input  logic [15:0]            hblank,
  input  logic [15:0]            vblank,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);
  localparam int SW = (SPARSE_OUTPUT > 0) ? $clog2(SPARSE_OUTPUT + 1) : 1;
  localparam logic [SW-1:0] SPARSE_MAX = SW'(SPARSE_OUTPUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LINE   = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            x_q, x_d, y_q, y_d, blank_q, blank_d;
  logic [SW-1:0]          sparse_q, sparse_d;
  logic [15:0]            ls_q, ls_d, lc_q, lc_d, hb_q, hb_d, vb_q, vb_d;
  logic                   stop_req_q, stop_req_d;
  logic [PIXEL_WIDTH-1:0] pix, do_d;
  logic                   de_d, hs_d, vs_d, frame_done_d;
  logic [15:0]            cfg_ls, cfg_lc;

  // Zero-sized lines/frames degenerate to a single pixel/line.
  assign cfg_ls = (line_size == 16'd0) ? 16'd1 : line_size;
  assign cfg_lc = (line_count == 16'd0) ? 16'd1 : line_count;

`ifdef VIDEO_STREAM_GEN_FRAME_SHIFT_EN
  logic [PIXEL_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  assign pix = PIXEL_WIDTH'(x_q) + PIXEL_WIDTH'(y_q) + frame_cnt_q;
`else
  assign pix = PIXEL_WIDTH'(x_q) + PIXEL_WIDTH'(y_q);
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    blank_d      = blank_q;
    sparse_d     = sparse_q;
    ls_d         = ls_q;
    lc_d         = lc_q;
    hb_d         = hb_q;
    vb_d         = vb_q;
    stop_req_d   = stop_req_q | stop;
    de_d         = 1'b0;
    hs_d         = 1'b0;
    vs_d         = 1'b0;
    do_d         = '0;
`ifdef VIDEO_STREAM_GEN_FRAME_SHIFT_EN
    frame_cnt_d  = frame_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        stop_req_d = 1'b0;
        if (start) begin
          ls_d       = cfg_ls;
          lc_d       = cfg_lc;
          hb_d       = hblank;
          vb_d       = vblank;
          x_d        = '0;
          y_d        = '0;
          blank_d    = '0;
          sparse_d   = '0;
          stop_req_d = stop;
`ifdef VIDEO_STREAM_GEN_FRAME_SHIFT_EN
          frame_cnt_d = '0;
`endif
          state_d    = LINE;
        end
      end
      LINE: begin
        sparse_d = (sparse_q == SPARSE_MAX) ? '0 : sparse_q + SW'(1);
        if (sparse_q == '0) begin
          de_d = 1'b1;
          hs_d = (x_q == 16'd0);
          vs_d = (x_q == 16'd0) && (y_q == 16'd0);
          do_d = pix;
          if (x_q == ls_q - 16'd1) begin
            // Last pixel of the line: skip the trailing sparse gap.
            x_d      = '0;
            blank_d  = '0;
            sparse_d = '0;
            if (y_q < lc_q - 16'd1) begin
              y_d     = y_q + 16'd1;
              state_d = HBLANK;
            end else begin
              state_d = VBLANK;
            end
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      HBLANK: begin
        if (blank_q == hb_q) begin
          blank_d  = '0;
          sparse_d = '0;
          state_d  = LINE;
        end else begin
          blank_d = blank_q + 16'd1;
        end
      end
      VBLANK: begin
        if (blank_q == vb_q) begin
          blank_d  = '0;
          x_d      = '0;
          y_d      = '0;
          sparse_d = '0;
`ifdef VIDEO_STREAM_GEN_FRAME_SHIFT_EN
          frame_cnt_d = frame_cnt_q + PIXEL_WIDTH'(1);
`endif
          if (stop_req_d) begin
            stop_req_d = 1'b0;
            state_d    = IDLE;
          end else begin
            ls_d    = cfg_ls;
            lc_d    = cfg_lc;
            hb_d    = hblank;
            vb_d    = vblank;
            state_d = LINE;
          end
        end else begin
          blank_d = blank_q + 16'd1;
        end
      end
      default: begin
        stop_req_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
    // Registered so the pulse coincides with the final VBLANK cycle itself.
    frame_done_d = (state_d == VBLANK) && (blank_d == vb_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      blank_q      <= '0;
      sparse_q     <= '0;
      ls_q         <= '0;
      lc_q         <= '0;
      hb_q         <= '0;
      vb_q         <= '0;
      stop_req_q   <= 1'b0;
      do_o         <= '0;
      de_o         <= 1'b0;
      hs_o         <= 1'b0;
      vs_o         <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
`ifdef VIDEO_STREAM_GEN_FRAME_SHIFT_EN
      frame_cnt_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      blank_q      <= blank_d;
      sparse_q     <= sparse_d;
      ls_q         <= ls_d;
      lc_q         <= lc_d;
      hb_q         <= hb_d;
      vb_q         <= vb_d;
      stop_req_q   <= stop_req_d;
      do_o         <= do_d;
      de_o         <= de_d;
      hs_o         <= hs_d;
      vs_o         <= vs_d;
      busy_o       <= (state_d != IDLE);
      frame_done_o <= frame_done_d;
`ifdef VIDEO_STREAM_GEN_FRAME_SHIFT_EN
      frame_cnt_q  <= frame_cnt_d;
`endif
    end
  end

endmodule

// File: doc/video_stream_gen.md
VIDEO_STREAM_GEN -- requirements
Module: video_stream_gen

Interface
REQ-001 Parameter PIXEL_WIDTH, default 12: width of do_o.
REQ-002 Parameter SPARSE_OUTPUT, default 2: idle cycles between consecutive pixels of a line; 0 means no gaps.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  level; sampled in IDLE to begin frame generation.
REQ-006 stop  input  1  pulse; requests halt at the next frame end.
REQ-007 line_size  input  16  pixels per line; 0 is treated as 1.
REQ-008 line_count  input  16  lines per frame; 0 is treated as 1.
REQ-009 hblank  input  16  HBLANK length minus 1, in cycles.
REQ-010 vblank  input  16  VBLANK length minus 1, in cycles.
REQ-011 do_o  output  PIXEL_WIDTH  pixel value, valid when de_o=1.
REQ-012 de_o  output  1  pixel valid strobe.
REQ-013 hs_o  output  1  high with de_o on the first pixel of every line.
REQ-014 vs_o  output  1  high with de_o on the first pixel of every frame.
REQ-015 busy_o  output  1  high whenever FSM is not IDLE.
REQ-016 frame_done_o  output  1  one-cycle pulse on the last VBLANK cycle.

Function
REQ-017 FSM states IDLE, LINE, HBLANK, VBLANK, encoded in 2 bits; an illegal encoding SHALL return to IDLE.
REQ-018 IDLE: start=1 -> latch line_size, line_count, hblank, vblank; x=0, y=0, sparse=0, frame_cnt=0; next state LINE.
REQ-019 LINE: sparse counts 0..SPARSE_OUTPUT and wraps; a pixel is emitted on each cycle with sparse=0, then x increments.
REQ-020 Pixel emitted at x=line_size-1: if y<line_count-1 -> HBLANK, y+1, x=0; else -> VBLANK; trailing sparse gap is not generated.
REQ-021 HBLANK lasts hblank+1 cycles, then LINE with sparse=0; VBLANK lasts vblank+1 cycles.
REQ-022 VBLANK end: frame_cnt+1, wrapping at 2^PIXEL_WIDTH; stop_req=1 -> IDLE; else relatch config, x=y=0, -> LINE.
REQ-023 All outputs registered: the pixel decided in a LINE cycle appears on do_o/de_o/hs_o/vs_o on the following cycle; first de_o is high 2 cycles after start is sampled.
REQ-024 hs_o = de_o and x=0; vs_o = de_o and x=0 and y=0; de_o=0 implies hs_o=vs_o=0 and do_o=0.
REQ-025 Pixel value do_o = (x + y) truncated to PIXEL_WIDTH bits (see REQ-031).
REQ-026 stop sampled high in any non-IDLE state sets stop_req; stop_req clears on entering IDLE; stop in IDLE without start is ignored.
REQ-027 start and stop high together in IDLE: exactly one frame is generated, then IDLE.
REQ-028 Config inputs changed mid-frame SHALL have no effect until the next frame start.

Reset
REQ-029 rst=1 immediately forces FSM to IDLE; all counters and stop_req go to 0; all outputs go to 0, including mid-line.
REQ-030 After rst deasserts, no output activity until start is sampled high.

Configuration
REQ-031 Macro VIDEO_STREAM_GEN_FRAME_SHIFT_EN: defined -> do_o = (x + y + frame_cnt) mod 2^PIXEL_WIDTH, so the pattern moves each frame; undefined -> do_o = (x + y) mod 2^PIXEL_WIDTH and frame_cnt logic is omitted.

Verification
REQ-032 SPARSE_OUTPUT=0, line_size=4, line_count=3, hblank=2, vblank=3, start held -> 12 de_o per frame; 22-cycle frame period; line 1 pixels 1,2,3,4; hs_o x3 per frame; vs_o x1 per frame.
REQ-033 SPARSE_OUTPUT=2, line_size=4 -> de_o at line cycles 0,3,6,9; line occupies 10 cycles before HBLANK.
REQ-034 start=stop=1 for one cycle in IDLE -> one frame generated, frame_done_o pulses once, busy_o falls on the next cycle.
REQ-035 rst pulse during the second line of a frame -> outputs 0 in the same cycle, no de_o until a new start, next frame begins with vs_o and do_o=0.
REQ-036 line_size=0, line_count=0 -> 1 pixel per frame with hs_o=vs_o=1.
REQ-037 Macro defined, PIXEL_WIDTH=4, 16 frames -> first pixel of frame n is n mod 16; macro undefined -> first pixel always 0.
